// File: rtl/thermal_frame_buffer.sv
// Double-buffered pixel-to-byte store: sensor writes one bank while SPI reads the other, swapping on frame completion when cs is idle.
// Optional 2-byte header (0xA5, swap counter) enabled by THERMAL_FRAME_BUFFER_HEADER_EN.
module thermal_frame_buffer #(
  parameter int PIXELS = 768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [15:0] pixel_data,
  output logic        pixel_ready,
  input  logic        cs,
  input  logic [13:0] data_address,
  output logic [7:0]  data,
  output logic        frame_ready,
  output logic        overrun
);

  localparam int BYTES = 2 * PIXELS;
`ifdef THERMAL_FRAME_BUFFER_HEADER_EN
  localparam int OFS = 2;
`else
  localparam int OFS = 0;
`endif
  localparam int BANK = BYTES + OFS;
  localparam int AW   = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [7:0]  lo_q, lo_d;
  logic        pending_q, pending_d;
  logic        valid_rd_q, valid_rd_d;
  logic        wr_bank_q, wr_bank_d;
  logic        frame_ready_q, frame_ready_d;
  logic        overrun_q, overrun_d;
  logic        cs_m_q, cs_s_q;
  logic [7:0]  data_q, data_d;
  logic        wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]  wr_dat;
  logic [AW-1:0] rd_idx;
  logic        swap;

  logic [7:0] mem [2][BYTES];

`ifdef THERMAL_FRAME_BUFFER_HEADER_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (swap) cnt_q <= cnt_q + 8'd1;
  end
`endif

  // Write path: each accepted pixel becomes two byte writes on consecutive cycles.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_dat      = '0;
    pixel_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          idx_d   = '0;
          state_d = WR_HI;
        end
      end
      WR_HI: begin
        if (frame_start) begin
          idx_d = '0;
        end else begin
          pixel_ready = 1'b1;
          if (pixel_valid) begin
            wr_en   = 1'b1;
            wr_addr = AW'({idx_q, 1'b0});
            wr_dat  = pixel_data[15:8];
            lo_d    = pixel_data[7:0];
            state_d = WR_LO;
          end
        end
      end
      WR_LO: begin
        if (frame_start) begin
          idx_d   = '0;
          state_d = WR_HI;
        end else begin
          wr_en   = 1'b1;
          wr_addr = AW'({idx_q, 1'b1});
          wr_dat  = lo_q;
          if (idx_q == 10'(PIXELS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = WR_HI;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A swap consumes the pending frame, so a coincident frame_start is not an overrun.
  always_comb begin
    swap          = pending_q && !cs_s_q;
    pending_d     = pending_q;
    wr_bank_d     = wr_bank_q;
    valid_rd_d    = valid_rd_q;
    frame_ready_d = frame_ready_q;
    overrun_d     = 1'b0;
    if (cs_s_q) frame_ready_d = 1'b0;
    if (swap) begin
      wr_bank_d     = ~wr_bank_q;
      pending_d     = 1'b0;
      valid_rd_d    = 1'b1;
      frame_ready_d = 1'b1;
    end else if (pending_q && frame_start) begin
      pending_d = 1'b0;
      overrun_d = 1'b1;
    end
    if (state_q == DONE) pending_d = 1'b1;
  end

  assign rd_idx = AW'(data_address - 14'(OFS));

  always_comb begin
    data_d = 8'h00;
    if (valid_rd_q && ({1'b0, data_address} < 15'(BANK))) begin
`ifdef THERMAL_FRAME_BUFFER_HEADER_EN
      if (data_address == 14'd0)      data_d = 8'hA5;
      else if (data_address == 14'd1) data_d = cnt_q;
      else                            data_d = mem[~wr_bank_q][rd_idx];
`else
      data_d = mem[~wr_bank_q][rd_idx];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank_q][wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      lo_q          <= '0;
      pending_q     <= 1'b0;
      valid_rd_q    <= 1'b0;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      cs_m_q        <= 1'b0;
      cs_s_q        <= 1'b0;
      data_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      lo_q          <= lo_d;
      pending_q     <= pending_d;
      valid_rd_q    <= valid_rd_d;
      wr_bank_q     <= wr_bank_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
      cs_m_q        <= cs;
      cs_s_q        <= cs_m_q;
      data_q        <= data_d;
    end
  end

  assign data        = data_q;
  assign frame_ready = frame_ready_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_thermal_frame_buffer.sv
// Directed/random bench for thermal_frame_buffer against a frame-level reference model.
module tb_thermal_frame_buffer;

  localparam int PIXELS = 768;
`ifdef THERMAL_FRAME_BUFFER_HEADER_EN
  localparam int OFS = 2;
`else
  localparam int OFS = 0;
`endif
  localparam int BANK = 2 * PIXELS + OFS;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic        pixel_ready;
  logic        cs;
  logic [13:0] data_address;
  logic [7:0]  data;
  logic        frame_ready;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int tp_viol = 0;

  logic [15:0] wr_px [PIXELS];
  logic [15:0] rd_px [PIXELS];
  bit          rd_valid = 1'b0;
  int          frame_cnt = 0;

  thermal_frame_buffer #(.PIXELS(PIXELS)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_ready(pixel_ready),
    .cs(cs), .data_address(data_address), .data(data),
    .frame_ready(frame_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int a);
    int p;
    if (!rd_valid || a >= BANK) return 8'h00;
`ifdef THERMAL_FRAME_BUFFER_HEADER_EN
    if (a == 0) return 8'hA5;
    if (a == 1) return 8'(frame_cnt);
`endif
    p = a - OFS;
    if (p % 2 == 0) return rd_px[p / 2][15:8];
    return rd_px[p / 2][7:0];
  endfunction

  task automatic model_swap();
    rd_px     = wr_px;
    rd_valid  = 1'b1;
    frame_cnt = (frame_cnt + 1) % 256;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input int a);
    data_address = 14'(a);
    @(negedge clk);
    chk(tag, 32'(data), 32'(exp_byte(a)));
  endtask

  task automatic rd_random(input int n);
    for (int k = 0; k < n; k++) rd_chk("rd_rand", int'($urandom_range(BANK + 16)));
    rd_chk("rd_last", BANK - 1);
    rd_chk("rd_oob", BANK);
    rd_chk("rd_top", 16383);
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Offers pixels with random gaps; counts a protocol violation if ready is seen right after an accept.
  task automatic push(input int n);
    int  sent = 0;
    int  budget = 0;
    bit  prev_acc = 1'b0;
    int  viol0 = tp_viol;
    while (sent < n && budget < 8 * n + 50) begin
      @(negedge clk);
      pixel_valid = ($urandom_range(3) != 0);
      pixel_data  = wr_px[sent];
      #1;
      if (prev_acc && pixel_ready !== 1'b0) tp_viol++;
      prev_acc = pixel_valid && (pixel_ready === 1'b1);
      if (prev_acc) sent++;
      budget++;
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    chk("push_count", 32'(sent), 32'(n));
    chk("throughput", 32'(tp_viol), 32'(viol0));
  endtask

  task automatic fill_random();
    for (int i = 0; i < PIXELS; i++) wr_px[i] = 16'($urandom);
  endtask

  initial begin
    int ov0;
    reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; pixel_data = '0;
    cs = 1'b0; data_address = '0;
    cycles(3);
    reset = 1'b0;
    chk("rst_pixel_ready", 32'(pixel_ready), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    chk("rst_frame_ready", 32'(frame_ready), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    rd_chk("pre_swap_a5", 5);
    chk("pre_swap_frame_ready", 32'(frame_ready), 32'(0));

    // Single frame of 0x0102, 0x0304, ...
    for (int i = 0; i < PIXELS; i++) wr_px[i] = {8'(2 * i + 1), 8'(2 * i + 2)};
    start_frame();
    push(PIXELS);
    cycles(6);
    model_swap();
    chk("single_frame_ready", 32'(frame_ready), 32'(1));
    data_address = 14'd0; @(negedge clk);
`ifdef THERMAL_FRAME_BUFFER_HEADER_EN
    chk("single_a0", 32'(data), 32'(8'hA5));
    data_address = 14'd1; @(negedge clk);
    chk("single_a1", 32'(data), 32'(8'h01));
    data_address = 14'd2; @(negedge clk);
    chk("single_a2", 32'(data), 32'(8'h01));
`else
    chk("single_a0", 32'(data), 32'(8'h01));
    data_address = 14'd3; @(negedge clk);
    chk("single_a3", 32'(data), 32'(8'h04));
`endif
    rd_random(24);

    // Deferred swap while cs held high
    cs = 1'b1;
    cycles(4);
    chk("cs_clears_frame_ready", 32'(frame_ready), 32'(0));
    fill_random();
    start_frame();
    push(PIXELS);
    cycles(10);
    chk("deferred_no_swap", 32'(frame_ready), 32'(0));
    rd_random(12);
    cs = 1'b0;
    cycles(3);
    chk("deferred_swap", 32'(frame_ready), 32'(1));
    model_swap();
    rd_random(16);

    // Overrun: frame A left pending, frame B replaces it
    cs = 1'b1;
    cycles(4);
    fill_random();
    start_frame();
    push(PIXELS);
    cycles(6);
    ov0 = ov_cnt;
    fill_random();
    start_frame();
    cycles(3);
    chk("overrun_pulse", 32'(ov_cnt), 32'(ov0 + 1));
    push(PIXELS);
    cycles(6);
    chk("overrun_no_swap", 32'(frame_ready), 32'(0));
    rd_random(8);
    cs = 1'b0;
    cycles(4);
    model_swap();
    chk("overrun_b_swapped", 32'(frame_ready), 32'(1));
    chk("overrun_once", 32'(ov_cnt), 32'(ov0 + 1));
    rd_random(16);

    // Mid-frame restart, then a full frame of 0xBEEF
    ov0 = ov_cnt;
    fill_random();
    start_frame();
    push(100);
    for (int i = 0; i < PIXELS; i++) wr_px[i] = 16'hBEEF;
    start_frame();
    push(PIXELS);
    cycles(6);
    model_swap();
    chk("restart_no_overrun", 32'(ov_cnt), 32'(ov0));
    chk("restart_frame_ready", 32'(frame_ready), 32'(1));
    for (int a = 0; a < BANK; a++) rd_chk("beef_byte", a);

    // Back-to-back random frames
    for (int f = 0; f < 2; f++) begin
      fill_random();
      start_frame();
      push(PIXELS);
      cycles(6);
      model_swap();
      rd_random(16);
    end

    // Reset mid-write
    fill_random();
    start_frame();
    push(400);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pixel_ready", 32'(pixel_ready), 32'(0));
    chk("midrst_data", 32'(data), 32'(0));
    chk("midrst_frame_ready", 32'(frame_ready), 32'(0));
    chk("midrst_overrun", 32'(overrun), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    rd_valid  = 1'b0;
    frame_cnt = 0;
    rd_chk("midrst_a0", 0);
    rd_chk("midrst_a10", 10);

    // Recovery after reset
    fill_random();
    start_frame();
    push(PIXELS);
    cycles(6);
    model_swap();
    chk("recover_frame_ready", 32'(frame_ready), 32'(1));
    rd_chk("recover_a0", 0);
    rd_chk("recover_a1", 1);
    rd_random(16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
